// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline, placed beside
//   the ID stage. It resolves three conditions in priority order:
//     1. data-memory wait   -> freeze every pipeline register
//     2. taken branch (MEM) -> flush IF/ID, ID/EX and EX/MEM for one cycle
//     3. load-use hazard    -> hold PC and IF/ID, insert one bubble into ID/EX
//   A memory wait longer than WAIT_MAX cycles sets a sticky timeout flag.
//   After that flag is set, mem_wait is ignored until the next reset.
//
// Optional feature:
//   HAZARD_PERF_CNT_EN  when defined, builds two saturating performance
//                       counters (stall_cycles, flush_events). When it is
//                       not defined, both outputs are tied to zero and no
//                       counter flops exist.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   id_valid            IF/ID holds a real instruction
//   id_rs, id_rt        ID source registers
//   id_uses_rt          ID instruction reads rt
//   ex_mem_read         load in EX
//   ex_rt               load destination register in EX
//   mem_br_taken        branch in MEM resolved taken
//   mem_wait            data memory not ready this cycle
//   pc_write            PC update enable
//   if_id_write         IF/ID load enable
//   id_ex_stall         zero the ID/EX control bits (bubble)
//   flush_if_id/id_ex/ex_mem  clear the respective pipeline register
//   pipe_freeze         hold every pipeline register
//   state               RUN=0 LOAD_USE=1 FLUSH=2 MEM_WAIT=3
//   mem_timeout         sticky: mem_wait exceeded WAIT_MAX cycles
//   stall_cycles        count of cycles with pc_write low
//   flush_events        count of branch flush cycles
module pipeline_hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic             mem_br_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_LOAD_USE = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_MEM_WAIT = 2'd3;

    // wait_cnt counts at most up to WAIT_MAX-1
    localparam int WC_W = $clog2(WAIT_MAX);

    logic [WC_W-1:0] wait_cnt;
    logic [1:0]      state_nxt;
    logic            lu_hazard;
    logic            wait_limit;
    logic            mw;
    logic            br;
    logic            lu;

    // Hazard detection and priority resolution
    always_comb begin
        lu_hazard = id_valid && ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) &&
                    (state != S_FLUSH);

        // The cycle that reaches the limit already counts as timed out:
        // the freeze is released in that cycle, and mem_wait is ignored
        // from then on.
        wait_limit = (state == S_MEM_WAIT) && mem_wait && !mem_timeout &&
                     (wait_cnt == WC_W'(WAIT_MAX - 1));

        mw = mem_wait && !mem_timeout && !wait_limit;
        br = !mw && mem_br_taken;
        lu = !mw && !mem_br_taken && lu_hazard;
    end

    // Control outputs and next state
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_stall  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        pipe_freeze  = 1'b0;
        state_nxt    = S_RUN;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_stall  = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_nxt    = S_RUN;
        end else if (mw) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
            state_nxt   = S_MEM_WAIT;
        end else if (br) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_nxt    = S_FLUSH;
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_stall = 1'b1;
            state_nxt   = S_LOAD_USE;
        end
    end

    // State, wait counter and sticky timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            // The counter advances only while the wait continues.
            // It is cleared on entry to, and on exit from, MEM_WAIT.
            if ((state == S_MEM_WAIT) && (state_nxt == S_MEM_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (wait_limit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (br && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
